// File: rtl/scs8hd_scan_pkg.sv
// Shared definitions for the scan-chain sequencer: host opcodes, FSM states, timing constants.
package scs8hd_scan_pkg;

    typedef enum logic [1:0] {
        OP_SHIFT       = 2'b00,
        OP_CAPTURE     = 2'b01,
        OP_SCS         = 2'b10,
        OP_CHAIN_RESET = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_SHIFT2,
        ST_RST,
        ST_DONE
    } state_e;

    // Cycles the chain reset is held low for a CHAIN_RESET command.
    localparam int RST_HOLD = 2;

endpackage

// File: rtl/scs8hd_scan_shreg.sv
// Indexed serializer/deserializer for one scan chain: holds the load pattern,
// collects SCAN_OUT bits by position and flags the last shift cycle.
import scs8hd_scan_pkg::*;

module scs8hd_scan_shreg #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:1] load_data,
    input  logic                 step,
    input  logic                 scan_in,
    output logic                 last,
    output logic                 next_bit,
    output logic [CHAIN_LEN-1:0] par_out
);

    // Bit 0 is presented straight from the command, so only bits 1.. are kept.
    logic [CHAIN_LEN-1:1] pattern;
    logic [CNT_W-1:0]     count;

    assign last = (count == CNT_W'(CHAIN_LEN - 1));

    always_comb begin
        // NOTE: default before the loop so every path assigns next_bit; no latch.
        next_bit = 1'b0;
        for (int i = 0; i < CHAIN_LEN - 1; i++) begin
            if (count == CNT_W'(i)) next_bit = pattern[i+1];
        end
    end

    // NOTE: the capture vector is reset too, so a RESET mid-shift discards partial data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count   <= '0;
            pattern <= '0;
            par_out <= '0;
        end else if (load) begin
            count   <= '0;
            pattern <= load_data;
        end else if (step) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (count == CNT_W'(i)) par_out[i] <= scan_in;
            end
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scs8hd_scan_seq.sv
// Scan-chain sequencer: SHIFT / CAPTURE / SHIFT-CAPTURE-SHIFT / CHAIN_RESET commands
// over a valid/ready handshake. Define SCAN_SEQ_PARITY_EN to add the SO_PARITY output.
import scs8hd_scan_pkg::*;

module scs8hd_scan_seq #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_OP,
    input  logic [CHAIN_LEN-1:0] SI_DATA,
    output logic [CHAIN_LEN-1:0] SO_DATA,
    output logic                 SO_VALID,
    output logic                 SCE,
    output logic                 SCD,
    output logic                 CHAIN_CKEN,
    output logic                 CHAIN_RESETB,
    input  logic                 SCAN_OUT,
    output logic                 BUSY
`ifdef SCAN_SEQ_PARITY_EN
    ,
    output logic                 SO_PARITY
`endif
);

    state_e               state;
    cmd_op_e              op_q;
    logic [1:0]           rst_cnt;
    logic                 accept;
    logic                 step;
    logic                 last;
    logic                 next_bit;
    logic [CHAIN_LEN-1:0] so_vec;

    assign CMD_READY = (state == ST_IDLE);
    assign BUSY      = (state != ST_IDLE);
    assign accept    = CMD_VALID && CMD_READY;
    assign step      = (state == ST_SHIFT) || (state == ST_SHIFT2);

    scs8hd_scan_shreg #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_shreg (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (accept),
        .load_data (SI_DATA[CHAIN_LEN-1:1]),
        .step      (step),
        .scan_in   (SCAN_OUT),
        .last      (last),
        .next_bit  (next_bit),
        .par_out   (so_vec)
    );

    // NOTE: all state and chain-facing outputs use non-blocking assignment so every
    // flop samples pre-edge values, matching the chain flops clocked by the same CLK.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            op_q         <= OP_SHIFT;
            rst_cnt      <= '0;
            SCE          <= 1'b0;
            SCD          <= 1'b0;
            CHAIN_CKEN   <= 1'b0;
            CHAIN_RESETB <= 1'b0;
            SO_DATA      <= '0;
            SO_VALID     <= 1'b0;
        end else begin
            SO_VALID     <= 1'b0;
            CHAIN_RESETB <= 1'b1;
            case (state)
                ST_IDLE: begin
                    SCE        <= 1'b0;
                    SCD        <= 1'b0;
                    CHAIN_CKEN <= 1'b0;
                    if (accept) begin
                        op_q <= cmd_op_e'(CMD_OP);
                        case (cmd_op_e'(CMD_OP))
                            OP_SHIFT, OP_SCS: begin
                                state      <= ST_SHIFT;
                                SCE        <= 1'b1;
                                CHAIN_CKEN <= 1'b1;
                                SCD        <= SI_DATA[0];
                            end
                            OP_CAPTURE: begin
                                state      <= ST_CAPTURE;
                                CHAIN_CKEN <= 1'b1;
                            end
                            default: begin
                                state        <= ST_RST;
                                rst_cnt      <= '0;
                                CHAIN_RESETB <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_SHIFT, ST_SHIFT2: begin
                    if (last) begin
                        SCE <= 1'b0;
                        SCD <= 1'b0;
                        if (state == ST_SHIFT && op_q == OP_SCS) begin
                            state      <= ST_CAPTURE;
                            CHAIN_CKEN <= 1'b1;
                        end else begin
                            state      <= ST_DONE;
                            CHAIN_CKEN <= 1'b0;
                        end
                    end else begin
                        // The unload pass flushes zeros behind the captured response.
                        SCD <= (state == ST_SHIFT2) ? 1'b0 : next_bit;
                    end
                end
                ST_CAPTURE: begin
                    if (op_q == OP_SCS) begin
                        state      <= ST_SHIFT2;
                        SCE        <= 1'b1;
                        SCD        <= 1'b0;
                        CHAIN_CKEN <= 1'b1;
                    end else begin
                        state      <= ST_DONE;
                        SCE        <= 1'b0;
                        CHAIN_CKEN <= 1'b0;
                    end
                end
                ST_RST: begin
                    CHAIN_CKEN <= 1'b0;
                    if (rst_cnt == 2'(RST_HOLD - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        rst_cnt      <= rst_cnt + 2'd1;
                        CHAIN_RESETB <= 1'b0;
                    end
                end
                ST_DONE: begin
                    SO_DATA  <= so_vec;
                    SO_VALID <= (op_q == OP_SHIFT) || (op_q == OP_SCS);
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SCAN_SEQ_PARITY_EN
    logic parity_acc;

    // Accumulated bit by bit; restarted before the unload pass of an SCS command.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            parity_acc <= 1'b0;
            SO_PARITY  <= 1'b0;
        end else begin
            if (accept || state == ST_CAPTURE) parity_acc <= 1'b0;
            else if (step)                     parity_acc <= parity_acc ^ SCAN_OUT;
            if (state == ST_DONE) SO_PARITY <= parity_acc;
        end
    end
`endif

endmodule

// File: tb/tb_scs8hd_scan_seq.sv
// Self-checking bench for scs8hd_scan_seq with an 8-flop chain model (D tied to 8'hA5).
module tb_scs8hd_scan_seq;
    import scs8hd_scan_pkg::*;

    localparam int              L       = 8;
    localparam logic [L-1:0]    D_CONST = 8'hA5;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [L-1:0] si_data;
    logic [L-1:0] so_data;
    logic         so_valid;
    logic         sce;
    logic         scd;
    logic         chain_cken;
    logic         chain_resetb;
    logic         scan_out;
    logic         busy;
`ifdef SCAN_SEQ_PARITY_EN
    logic         so_parity;
`endif

    logic [L-1:0] chain_q;
    int           n_checks = 0;
    int           n_pass   = 0;

    scs8hd_scan_seq #(.CHAIN_LEN(L)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .CMD_VALID    (cmd_valid),
        .CMD_READY    (cmd_ready),
        .CMD_OP       (cmd_op),
        .SI_DATA      (si_data),
        .SO_DATA      (so_data),
        .SO_VALID     (so_valid),
        .SCE          (sce),
        .SCD          (scd),
        .CHAIN_CKEN   (chain_cken),
        .CHAIN_RESETB (chain_resetb),
        .SCAN_OUT     (scan_out),
        .BUSY         (busy)
`ifdef SCAN_SEQ_PARITY_EN
        ,
        .SO_PARITY    (so_parity)
`endif
    );

    always #5 clk = ~clk;

    // Chain model: flop 0 takes SCD, flop L-1 drives SCAN_OUT.
    always @(posedge clk or negedge chain_resetb) begin
        if (!chain_resetb)   chain_q <= '0;
        else if (chain_cken) chain_q <= sce ? {chain_q[L-2:0], scd} : D_CONST;
    end
    assign scan_out = chain_q[L-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else             n_pass++;
    endtask

    typedef struct {
        cmd_op_e      op;
        logic [L-1:0] si;
        logic         exp_valid;
        logic [L-1:0] exp_so;
        int           exp_lat;
        int           exp_cap;
        int           exp_crst;
    } vec_t;

    vec_t vecs[11];

    task automatic run_cmd(input int idx, input vec_t v);
        int           lat, n_valid, n_cap, n_crst, n_rdy;
        logic [L-1:0] so_seen;
        logic         par_seen;
        bit           done;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        si_data   = v.si;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 0; n_valid = 0; n_cap = 0; n_crst = 0; n_rdy = 0;
        so_seen = '0; par_seen = 1'b0; done = 0;
        while (!done && lat < 100) begin
            if (so_valid) begin
                n_valid++;
                so_seen = so_data;
`ifdef SCAN_SEQ_PARITY_EN
                par_seen = so_parity;
`endif
            end
            if (!sce && chain_cken) n_cap++;
            if (!chain_resetb)      n_crst++;
            if (busy && cmd_ready)  n_rdy++;
            if (!busy) done = 1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check($sformatf("v%0d completed", idx), 64'(done), 64'(1));
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d so_valid pulses", idx), 64'(n_valid), 64'(v.exp_valid ? 1 : 0));
        if (v.exp_valid) check($sformatf("v%0d so_data", idx), 64'(so_seen), 64'(v.exp_so));
`ifdef SCAN_SEQ_PARITY_EN
        if (v.exp_valid) check($sformatf("v%0d so_parity", idx), 64'(par_seen), 64'(^v.exp_so));
`else
        if (par_seen) check($sformatf("v%0d parity unexpected", idx), 64'(par_seen), 64'(0));
`endif
        check($sformatf("v%0d capture cycles", idx), 64'(n_cap), 64'(v.exp_cap));
        check($sformatf("v%0d chain reset cycles", idx), 64'(n_crst), 64'(v.exp_crst));
        check($sformatf("v%0d ready while busy", idx), 64'(n_rdy), 64'(0));
        @(posedge clk);
        #1;
        check($sformatf("v%0d so_valid one cycle", idx), 64'(so_valid), 64'(0));
    endtask

    initial begin
        int           e, t_valid, t_acc2, n_rdy, n_v, lat2;
        bit           prev_busy;
        logic [L-1:0] first_so;

        // Chain contents tracked by hand across the sequence (bit 0 unloads first).
        vecs[0]  = '{OP_SHIFT,       8'h3C, 1'b1, 8'h00,  9, 0, 0};
        vecs[1]  = '{OP_SCS,         8'hFF, 1'b1, 8'hA5, 18, 1, 0};
        vecs[2]  = '{OP_SHIFT,       8'h07, 1'b1, 8'h00,  9, 0, 0};
        vecs[3]  = '{OP_SHIFT,       8'h03, 1'b1, 8'h07,  9, 0, 0};
        vecs[4]  = '{OP_SHIFT,       8'hC3, 1'b1, 8'h03,  9, 0, 0};
        vecs[5]  = '{OP_CAPTURE,     8'h00, 1'b0, 8'h00,  2, 1, 0};
        vecs[6]  = '{OP_SHIFT,       8'h00, 1'b1, 8'hA5,  9, 0, 0};
        vecs[7]  = '{OP_SHIFT,       8'h96, 1'b1, 8'h00,  9, 0, 0};
        vecs[8]  = '{OP_CHAIN_RESET, 8'h00, 1'b0, 8'h00,  3, 0, 2};
        vecs[9]  = '{OP_SHIFT,       8'h11, 1'b1, 8'h00,  9, 0, 0};
        vecs[10] = '{OP_SCS,         8'h0F, 1'b1, 8'hA5, 18, 1, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; si_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset busy", 64'(busy), 64'(0));
        check("reset sce", 64'(sce), 64'(0));
        check("reset scd", 64'(scd), 64'(0));
        check("reset chain_cken", 64'(chain_cken), 64'(0));
        check("reset chain_resetb", 64'(chain_resetb), 64'(0));
        check("reset so_data", 64'(so_data), 64'(0));
        check("reset so_valid", 64'(so_valid), 64'(0));
`ifdef SCAN_SEQ_PARITY_EN
        check("reset so_parity", 64'(so_parity), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("chain_resetb before first edge", 64'(chain_resetb), 64'(0));
        @(posedge clk);
        #1;
        check("chain_resetb after first edge", 64'(chain_resetb), 64'(1));
        check("cmd_ready after reset", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 11; i++) run_cmd(i, vecs[i]);

        // Back-to-back SHIFTs with CMD_VALID held high; chain holds 8'h00 here.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SHIFT; si_data = 8'h5A;
        @(posedge clk);
        #1;
        si_data = 8'h81;
        e = 0; t_valid = -1; t_acc2 = -1; n_rdy = 0; prev_busy = busy; first_so = 'x;
        while (t_acc2 < 0 && e < 100) begin
            @(posedge clk);
            #1;
            e++;
            if (so_valid) begin t_valid = e; first_so = so_data; end
            if (busy && !prev_busy) t_acc2 = e;
            if (t_valid < 0 && busy && cmd_ready) n_rdy++;
            prev_busy = busy;
        end
        cmd_valid = 1'b0;
        check("queued first so_valid time", 64'(t_valid), 64'(9));
        check("queued second accept time", 64'(t_acc2), 64'(10));
        check("queued first so_data", 64'(first_so), 64'(8'h00));
        check("queued ready during first", 64'(n_rdy), 64'(0));
        lat2 = 0;
        while (!so_valid && lat2 < 100) begin
            @(posedge clk);
            #1;
            lat2++;
        end
        check("queued second latency", 64'(lat2), 64'(9));
        check("queued second so_data", 64'(so_data), 64'(8'h5A));

        // RESET asserted mid-SHIFT once the counter has reached 4.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SHIFT; si_data = 8'h3C;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop reset sce", 64'(sce), 64'(0));
        check("midop reset chain_resetb", 64'(chain_resetb), 64'(0));
        check("midop reset busy", 64'(busy), 64'(0));
        check("midop reset so_data", 64'(so_data), 64'(0));
        check("midop reset cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_v = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (so_valid) n_v++;
        end
        check("midop reset no so_valid", 64'(n_v), 64'(0));
        check("midop reset so_data stays 0", 64'(so_data), 64'(0));
        check("midop reset idle", 64'(busy), 64'(0));
        check("midop reset chain_resetb released", 64'(chain_resetb), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scs8hd_scan_seq.md
Name: scs8hd_scan_seq

Overview:
- Sequencer for one scan chain of CHAIN_LEN scan flops that share CLK with this block. Each flop has a D/SCD mux, SCE select and a RESETB pin.
- Drives the chain's shared SCE, serial SCD input, clock enable and active-low chain reset.
- Accepts one command at a time from a test host over a valid/ready handshake: shift, capture, or shift-capture-shift.
- Loads a parallel pattern serially, pulses capture, and unloads the previous chain contents in parallel.

Parameters:
- CHAIN_LEN, 32, number of scan flops in the chain (2..1024).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter.

Ports:
- CLK  input  1  clock; also clocks the chain.
- RESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  host command valid.
- CMD_READY  output  1  block can accept a command.
- CMD_OP  input  2  00 SHIFT, 01 CAPTURE, 10 SHIFT_CAPTURE_SHIFT (SCS), 11 CHAIN_RESET.
- SI_DATA  input  CHAIN_LEN  pattern to load, sampled on the handshake; bit 0 is shifted first.
- SO_DATA  output  CHAIN_LEN  unloaded chain contents; bit 0 is the first bit out.
- SO_VALID  output  1  one-cycle pulse: SO_DATA updated.
- SCE  output  1  scan enable to the chain.
- SCD  output  1  serial data to the first flop.
- CHAIN_CKEN  output  1  chain clock enable; chain holds its state when 0.
- CHAIN_RESETB  output  1  active-low reset to the chain flops.
- SCAN_OUT  input  1  Q of the last chain flop.
- BUSY  output  1  state is not IDLE.

Behaviour:
- Reset values: state IDLE, CMD_READY 1, SCE 0, SCD 0, CHAIN_CKEN 0, CHAIN_RESETB 0, SO_DATA 0, SO_VALID 0, BUSY 0, counter 0.
- CHAIN_RESETB deasserts on the first CLK edge after RESET falls.
- All chain-facing outputs are registered.
- Handshake:
  - A command is accepted when CMD_VALID && CMD_READY at a CLK edge.
  - CMD_READY = (state == IDLE).
  - CMD_OP and SI_DATA are captured into a shadow register on accept.
  - The host may hold CMD_VALID high across commands.
- States: IDLE, SHIFT, CAPTURE, SHIFT2, RST, DONE.
- IDLE: SCE 0, CHAIN_CKEN 0. On accept:
  - SHIFT / SCS → SHIFT.
  - CAPTURE → CAPTURE.
  - CHAIN_RESET → RST.
- SHIFT (CHAIN_LEN cycles):
  - SCE 1, CHAIN_CKEN 1.
  - SCD = shadow bit[counter].
  - Each edge: SO shift register bit[counter] <= SCAN_OUT; counter increments.
  - On the last edge (counter == CHAIN_LEN-1):
    - SCS → CAPTURE.
    - Otherwise → DONE.
  - Counter resets to 0 on leaving SHIFT.
- CAPTURE (exactly 1 cycle):
  - SCE 0, CHAIN_CKEN 1; the chain loads functional D.
  - Next state: SCS → SHIFT2; CAPTURE → DONE.
- SHIFT2 (CHAIN_LEN cycles): same as SHIFT, but SCD = 0 (flush); unloads the captured response.
- RST (2 cycles): CHAIN_RESETB 0, CHAIN_CKEN 0, then → DONE.
- DONE (1 cycle):
  - SO_DATA <= SO shift register.
  - SO_VALID pulses high unless the op was CAPTURE or CHAIN_RESET.
  - Then → IDLE.
- Latency, accept to SO_VALID:
  - SHIFT: CHAIN_LEN+1 cycles.
  - SCS: 2*CHAIN_LEN+2 cycles.
  - CAPTURE: 2 cycles, no SO_VALID.
  - CHAIN_RESET: 3 cycles, no SO_VALID.
- Boundaries:
  - CMD_VALID during non-IDLE is ignored (not dropped; held by the host).
  - Counter compares to CHAIN_LEN-1, never wraps past it.
  - RESET mid-operation: immediate return to reset values. The chain sees CHAIN_RESETB 0 and SCE 0, and the partial SO shift register is discarded; SO_DATA returns to 0.
  - SCAN_OUT X during SHIFT propagates X into SO_DATA (no masking).

Optional Feature:
- SCAN_SEQ_PARITY_EN defined:
  - Adds output SO_PARITY (1 bit), the XOR of all CHAIN_LEN bits shifted in from SCAN_OUT, valid with SO_VALID.
  - Reset value 0.
  - Computed incrementally during SHIFT/SHIFT2, not from the final vector.
- Undefined: port and logic absent.

Decomposition:
- Shared package scs8hd_scan_pkg holds:
  - CMD_OP encodings (OP_SHIFT, OP_CAPTURE, OP_SCS, OP_CHAIN_RESET).
  - The state enum.
  - The RST hold count constant (2).
- One sub-module, scs8hd_scan_shreg: CHAIN_LEN-bit indexed serializer/deserializer with counter and done flag, instantiated once and reused for SHIFT and SHIFT2.

Test Plan:
- Bench: chain model of 8 scan flops, CHAIN_LEN=8, D tied to per-flop constant 8'hA5.
- RESET high 3 cycles then low → outputs at reset values, CHAIN_RESETB 1 from next edge, CMD_READY 1.
- SHIFT SI_DATA=8'h3C on chain holding 8'h00 → SO_VALID at accept+9, SO_DATA=8'h00; chain then holds 8'h3C.
- SCS with SI_DATA=8'hFF after the above:
  - SCE low exactly 1 cycle mid-op.
  - Two SO_VALIDs are not required: one SO_VALID at accept+18 with SO_DATA=8'hA5 (captured response).
- CMD_VALID held high with two queued SHIFTs → second accept occurs exactly 1 cycle after first SO_VALID; CMD_READY 0 throughout the first.
- RESET asserted at counter=4 of SHIFT → SCE 0, CHAIN_RESETB 0 same cycle, SO_VALID never pulses, BUSY 0.
- Parity (SCAN_SEQ_PARITY_EN): unload 8'h07 → SO_PARITY=1; unload 8'h03 → SO_PARITY=0.
